// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Memory-side controller for a 16-bit CPU datapath. It accepts one load/store
// request at a time from the control unit, latches the address into MAR and
// the write data into MDR, then drives a wait-state memory port until the
// memory acknowledges or a timeout expires. Each request completes with a
// one-cycle response pulse that carries the read data or a timeout error.
//
// Ports
//   clk, rst_n         clock (posedge) / asynchronous active-low reset
//   req_valid/ready    request handshake from the control unit
//   req_we             1 = store, 0 = load
//   req_addr/wdata     request address / store data
//   rsp_valid          one-cycle completion pulse (no backpressure)
//   rsp_rdata/err      MDR contents / timeout flag, valid with rsp_valid
//   mem_en/we          memory access strobe / write enable
//   mem_addr/wdata     memory address (MAR) / write data (MDR)
//   mem_rdata/ack      memory read data / access complete this cycle
//   dbg_state          current FSM state (0 = IDLE, 1 = ACCESS, 2 = RESP)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a request held
// while busy is neither consumed nor dropped; the requester simply keeps it
// up until it is accepted. The response has no ready: the consumer must take
// it during the single cycle rsp_valid is high.
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q,   mar_d;
  logic [DATA_W-1:0]   mdr_q,   mdr_d;
  logic                we_q,    we_d;
  logic                err_q,   err_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mar_d   = req_addr;
          mdr_d   = req_wdata;
          we_d    = req_we;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // The ack is tested first so an ack on the final timeout cycle
        // still completes the access cleanly.
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are glitch-free and
  // constant for the whole ACCESS phase, and reset drops them asynchronously.
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (state_q == ST_ACCESS) && we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  // A store returns its own data because MDR still holds the write value.
  assign rsp_rdata = (state_q == ST_RESP) ? mdr_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl: reset values, a table of directed
// transactions, hand-written corner sequences (stray ack, request held while
// busy, reset mid-access) and randomized transactions scored against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: an access with `waits` wait states is acked
  // after waits+1 cycles unless that exceeds the timeout window, in which case
  // it ends after TO cycles with an error. MDR starts as the write data and
  // is replaced only by data from an acked load.
  task automatic model(input logic we, input logic [DW-1:0] wdata, input int waits,
                       input logic [DW-1:0] memdata, output logic [DW-1:0] rdata,
                       output logic err, output int cycles);
    logic acked;
    acked  = (waits < TO);
    cycles = acked ? waits + 1 : TO;
    err    = !acked;
    rdata  = (!we && acked) ? memdata : wdata;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one full transaction. Inputs change on the falling edge, outputs
  // are sampled on the falling edge. The memory acks in ACCESS cycle `waits`
  // (waits >= TO means it never acks).
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic [DW-1:0] memdata,
                         input logic [DW-1:0] exp_rdata, input logic exp_err,
                         input int exp_cycles, input logic hold);
    int            n_acc;
    logic          got_rsp;
    logic          mem_ok;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    check("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back(exp_rdata);
    n_acc   = 0;
    got_rsp = 1'b0;
    mem_ok  = 1'b1;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clk);
      // Scramble the request bus after acceptance: MAR/MDR must hold.
      req_valid = hold;
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      req_we    = 1'($urandom);
      mem_ack   = 1'b0;
      mem_rdata = DW'($urandom);
      if (rsp_valid) begin
        got_rsp = 1'b1;
        break;
      end
      if (!mem_en) break;
      n_acc++;
      if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== we || req_ready !== 1'b0)
        mem_ok = 1'b0;
      if (k == waits) begin
        mem_ack   = 1'b1;
        mem_rdata = memdata;
      end
    end
    req_valid = 1'b0;
    check("access_stable", mem_ok, 1'b1);
    check("access_cycles", n_acc, exp_cycles);
    check("rsp_valid_seen", got_rsp, 1'b1);
    check("rsp_mem_en_low", mem_en, 1'b0);
    exp_d = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", rsp_err, exp_err);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 1'b0);
    check("idle_after_rsp", req_ready, 1'b1);
    check("no_extra_access", mem_en, 1'b0);
    check("mdr_retained", mem_wdata, exp_d);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] memdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    logic          stray_ok;
    logic          we_r;
    int            waits_r, r;
    logic [DW-1:0] md_r, wd_r, rd_e;
    logic [AW-1:0] ad_r;
    logic          err_e;
    int            cyc_e;

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;   mem_ack = 1'b0;

    // Reset values, checked while reset is still asserted.
    #2;
    check("rst_state",     dbg_state, 2'd0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err",   rsp_err,   1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_mem_en",    mem_en,    1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_mar",       mem_addr,  16'h0);
    check("rst_mdr",       mem_wdata, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //        we    addr      wdata     waits   memdata   rdata     err   cycles
    vecs[0] = '{1'b0, 16'h3000, 16'h0000, 0,      16'hBEEF, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h4000, 16'h1234, 3,      16'h0F0F, 16'h1234, 1'b0, 4};
    vecs[2] = '{1'b0, 16'h5000, 16'h5A5A, TO,     16'h0000, 16'h5A5A, 1'b1, TO};
    vecs[3] = '{1'b0, 16'h6000, 16'h0000, TO - 1, 16'hCAFE, 16'hCAFE, 1'b0, TO};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 0,      16'h0000, 16'hFFFF, 1'b0, 1};
    vecs[5] = '{1'b0, 16'h0000, 16'h1111, 1,      16'h0000, 16'h0000, 1'b0, 2};

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].memdata,
              vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cycles, 1'b0);

    // Stray ack while idle must not touch MDR or start an access.
    run_txn(1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0, 1, 1'b0);
    stray_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      if (mem_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 2'd0)
        stray_ok = 1'b0;
    end
    mem_ack = 1'b0;
    check("stray_ack_no_state_change", stray_ok, 1'b1);
    check("stray_ack_mdr", mem_wdata, 16'hBEEF);

    // Request held high through the whole access: exactly one access.
    run_txn(1'b1, 16'h4000, 16'h1234, 2, 16'h0000, 16'h1234, 1'b0, 3, 1'b1);
    run_txn(1'b0, 16'h4000, 16'h0000, 1, 16'h7777, 16'h7777, 1'b0, 2, 1'b0);

    // Reset in the middle of an access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_in_access", mem_en, 1'b1);
    check("midrst_mar", mem_addr, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_en",    mem_en,    1'b0);
    check("midrst_mem_we",    mem_we,    1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_mar_clr",   mem_addr,  16'h0);
    check("midrst_mdr_clr",   mem_wdata, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1;
      mem_rdata = 16'hAAAA;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_en !== 1'b0) stray_ok = 1'b0;
    end
    mem_ack = 1'b0;
    check("midrst_no_rsp_after", stray_ok, 1'b1);
    run_txn(1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0, 1, 1'b0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      we_r = 1'($urandom_range(0, 1));
      ad_r = AW'($urandom);
      wd_r = DW'($urandom);
      md_r = DW'($urandom);
      r    = $urandom_range(0, 19);
      if (r < 16)       waits_r = r % 8;
      else if (r == 16) waits_r = TO - 1;
      else if (r == 17) waits_r = TO;
      else              waits_r = r;
      model(we_r, wd_r, waits_r, md_r, rd_e, err_e, cyc_e);
      run_txn(we_r, ad_r, wd_r, waits_r, md_r, rd_e, err_e, cyc_e, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
